// File: rtl/pe_conv_sequencer.sv
// Sequencer for one 1-D convolution pass over a PE scratchpad: reads weight/activation pairs,
// accumulates, writes each partial sum back. Define PE_SEQ_SATURATE_EN to saturate write-back.
module pe_conv_sequencer #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned ADDRESS_WIDTH = 9,
  parameter int unsigned WEIGHT_BASE   = 0,
  parameter int unsigned ACT_BASE      = 100,
  parameter int unsigned PSUM_BASE     = 500,
  parameter int unsigned KERNEL_SIZE   = 3,
  parameter int unsigned ACT_SIZE      = 5
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     start_i,
  input  logic                     abort_i,
  output logic                     spad_read_enable_o,
  output logic [ADDRESS_WIDTH-1:0] spad_read_address_o,
  input  logic [DATA_WIDTH-1:0]    spad_read_data_i,
  output logic                     spad_write_enable_o,
  output logic [ADDRESS_WIDTH-1:0] spad_write_address_o,
  output logic [DATA_WIDTH-1:0]    spad_write_data_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [ADDRESS_WIDTH-1:0] out_index_o
);

  localparam int unsigned NumOut = ACT_SIZE - KERNEL_SIZE + 1;
  localparam int unsigned AccW   = 2 * DATA_WIDTH + $clog2(KERNEL_SIZE) + 1;
  localparam int unsigned ProdW  = 2 * DATA_WIDTH;

  typedef enum logic [2:0] {StIdle, StRdW, StRdA, StMac, StWr, StFin} state_e;

  state_e                        state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]      k_q, k_d;
  logic [ADDRESS_WIDTH-1:0]      o_q, o_d;
  logic signed [AccW-1:0]        acc_q, acc_d;
  logic signed [DATA_WIDTH-1:0]  w_q, w_d;
  logic signed [ProdW-1:0]       prod;
  logic [DATA_WIDTH-1:0]         narrow_acc;

  // Operands are sign-extended to the product width before multiplying.
  assign prod = ProdW'(w_q) * ProdW'($signed(spad_read_data_i));

`ifdef PE_SEQ_SATURATE_EN
  localparam logic signed [AccW-1:0] SatMax = {{(AccW-DATA_WIDTH+1){1'b0}},
                                              {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [AccW-1:0] SatMin = ~SatMax;

  always_comb begin
    if (acc_q > SatMax) begin
      narrow_acc = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if (acc_q < SatMin) begin
      narrow_acc = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      narrow_acc = acc_q[DATA_WIDTH-1:0];
    end
  end
`else
  assign narrow_acc = acc_q[DATA_WIDTH-1:0];
`endif

  always_comb begin
    state_d              = state_q;
    k_d                  = k_q;
    o_d                  = o_q;
    acc_d                = acc_q;
    w_d                  = w_q;
    spad_read_enable_o   = 1'b0;
    spad_read_address_o  = '0;
    spad_write_enable_o  = 1'b0;
    spad_write_address_o = '0;
    spad_write_data_o    = '0;
    busy_o               = 1'b0;
    done_o               = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i && !abort_i) begin
          k_d     = '0;
          o_d     = '0;
          acc_d   = '0;
          state_d = StRdW;
        end
      end
      StRdW: begin
        busy_o              = 1'b1;
        spad_read_enable_o  = 1'b1;
        spad_read_address_o = ADDRESS_WIDTH'(WEIGHT_BASE) + k_q;
        state_d             = StRdA;
      end
      StRdA: begin
        busy_o              = 1'b1;
        w_d                 = $signed(spad_read_data_i);
        spad_read_enable_o  = 1'b1;
        spad_read_address_o = ADDRESS_WIDTH'(ACT_BASE) + o_q + k_q;
        state_d             = StMac;
      end
      StMac: begin
        busy_o = 1'b1;
        acc_d  = acc_q + AccW'(prod);
        if (k_q == ADDRESS_WIDTH'(KERNEL_SIZE - 1)) begin
          state_d = StWr;
        end else begin
          k_d     = k_q + 1'b1;
          state_d = StRdW;
        end
      end
      StWr: begin
        busy_o               = 1'b1;
        spad_write_enable_o  = 1'b1;
        spad_write_address_o = ADDRESS_WIDTH'(PSUM_BASE) + o_q;
        spad_write_data_o    = narrow_acc;
        acc_d                = '0;
        k_d                  = '0;
        if (o_q == ADDRESS_WIDTH'(NumOut - 1)) begin
          state_d = StFin;
        end else begin
          o_d     = o_q + 1'b1;
          state_d = StRdW;
        end
      end
      StFin: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Abort cancels the pass outright, including a write that would land this cycle.
    if (abort_i && busy_o) begin
      state_d              = StIdle;
      k_d                  = '0;
      o_d                  = '0;
      acc_d                = '0;
      spad_write_enable_o  = 1'b0;
      spad_write_address_o = '0;
      spad_write_data_o    = '0;
    end
  end

  assign out_index_o = o_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      k_q     <= '0;
      o_q     <= '0;
      acc_q   <= '0;
      w_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      o_q     <= o_d;
      acc_q   <= acc_d;
      w_q     <= w_d;
    end
  end

endmodule

// File: tb/tb_pe_conv_sequencer.sv
// Bench for pe_conv_sequencer: scratchpad model, table of convolution vectors, directed
// abort/restart/reset sequences.
module tb_pe_conv_sequencer;

  localparam int DW = 16;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          ren, wen, busy, done;
  logic [AW-1:0] raddr, waddr, oidx;
  logic [DW-1:0] rdata, wdata;
  logic [DW-1:0] mem [0:511];

  int n_vec = 0;
  int n_err = 0;

  pe_conv_sequencer dut (
    .clk_i               (clk),
    .reset_i             (reset),
    .start_i             (start),
    .abort_i             (abort),
    .spad_read_enable_o  (ren),
    .spad_read_address_o (raddr),
    .spad_read_data_i    (rdata),
    .spad_write_enable_o (wen),
    .spad_write_address_o(waddr),
    .spad_write_data_o   (wdata),
    .busy_o              (busy),
    .done_o              (done),
    .out_index_o         (oidx)
  );

  always #5 clk = ~clk;

  // Scratchpad read port: data valid one cycle after the request.
  always @(posedge clk) if (ren) rdata <= mem[raddr];

  typedef struct packed {
    logic [2:0][15:0] w;
    logic [4:0][15:0] a;
    logic [2:0][15:0] e;
  } vec_t;

  vec_t cur;
  vec_t tbl [9];

  function automatic logic [15:0] model(input vec_t v, input int o);
    longint s = 0;
    for (int k = 0; k < 3; k++) begin
      s += longint'($signed(v.w[k])) * longint'($signed(v.a[o+k]));
    end
`ifdef PE_SEQ_SATURATE_EN
    if (s > 32767) return 16'h7FFF;
    if (s < -32768) return 16'h8000;
`endif
    return s[15:0];
  endfunction

  task automatic chk(input string name, input longint got, input longint exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic load(input vec_t v);
    cur = v;
    for (int i = 0; i < 3; i++) mem[i] = v.w[i];
    for (int i = 0; i < 5; i++) mem[100+i] = v.a[i];
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " ren"}, ren, 0);
    chk({tag, " raddr"}, raddr, 0);
    chk({tag, " wen"}, wen, 0);
    chk({tag, " waddr"}, waddr, 0);
    chk({tag, " wdata"}, wdata, 0);
    chk({tag, " out_index"}, oidx, 0);
  endtask

  // Pulses start, then walks cycles 1..40 after the start edge checking every output.
  task automatic run_pass(input string tag, input int abort_cyc, input int re1, input int re2);
    int  nw = 0;
    int  nd = 0;
    int  exp_nw = 0;
    bit  exp_b, exp_w;
    for (int j = 1; j <= 3; j++) if (abort_cyc == 0 || 10 * j < abort_cyc) exp_nw++;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      abort = (c == abort_cyc);
      start = (c == re1) || (c == re2);
      #1;
      exp_b = (c <= 30) && (abort_cyc == 0 || c <= abort_cyc);
      exp_w = (c % 10 == 0) && (c <= 30) && (abort_cyc == 0 || c < abort_cyc);
      chk($sformatf("%s busy c%0d", tag, c), busy, exp_b);
      chk($sformatf("%s done c%0d", tag, c), done, (c == 31) && (abort_cyc == 0));
      chk($sformatf("%s wen c%0d", tag, c), wen, exp_w);
      chk($sformatf("%s rw_overlap c%0d", tag, c), ren & wen, 0);
      if (exp_b) chk($sformatf("%s out_index c%0d", tag, c), oidx, (c - 1) / 10);
      if (wen && exp_w) begin
        chk($sformatf("%s waddr c%0d", tag, c), waddr, 500 + c / 10 - 1);
        chk($sformatf("%s wdata c%0d", tag, c), wdata, cur.e[c/10-1]);
      end
      if (wen) nw++;
      if (done) nd++;
      @(negedge clk);
    end
    abort = 1'b0;
    start = 1'b0;
    chk({tag, " write_count"}, nw, exp_nw);
    chk({tag, " done_count"}, nd, (abort_cyc == 0) ? 1 : 0);
  endtask

  initial begin
    #2;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    // Packed concatenations list the highest index first.
    tbl[0].w = {16'd3, 16'd2, 16'd1};
    tbl[0].a = {16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
    tbl[0].e = {16'd26, 16'd20, 16'd14};
    tbl[1].w = {16'h0001, 16'h0000, 16'hFFFF};
    tbl[1].a = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
    tbl[1].e = {16'hFFFE, 16'hFFFE, 16'hFFFE};
    tbl[2].w = {3{16'h7FFF}};
    tbl[2].a = {5{16'h7FFF}};
`ifdef PE_SEQ_SATURATE_EN
    tbl[2].e = {3{16'h7FFF}};
`else
    tbl[2].e = {3{16'h0003}};
`endif
    for (int i = 3; i < 9; i++) begin
      for (int k = 0; k < 3; k++) tbl[i].w[k] = 16'($urandom);
      for (int k = 0; k < 5; k++) tbl[i].a[k] = 16'($urandom);
      for (int o = 0; o < 3; o++) tbl[i].e[o] = model(tbl[i], o);
    end

    for (int i = 0; i < 9; i++) begin
      load(tbl[i]);
      run_pass($sformatf("vec%0d", i), 0, 0, 0);
    end

    load(tbl[0]);
    run_pass("abort15", 15, 0, 0);
    run_pass("after_abort", 0, 0, 0);
    run_pass("repulse", 0, 5, 31);
    run_pass("abort_wr", 20, 0, 0);

    // abort and start together in IDLE: abort wins
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("abort_start busy c%0d", c), busy, 0);
      chk($sformatf("abort_start ren c%0d", c), ren, 0);
      @(negedge clk);
    end

    // reset while in MAC (cycle 3 of the pass)
    load(tbl[1]);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("pre_reset busy", busy, 1);
    reset = 1'b1;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    run_pass("post_reset", 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
